// File: rtl/rf_writeback.sv
// rf_writeback: write-back stage and register scoreboard.
// The ALU and load results are each buffered in a small FIFO. A round-robin
// arbiter pops one head per cycle into a registered register-file write port.
// A per-register busy vector is set by decode on issue and cleared on commit.

`ifndef RF_WRITE
`define RF_WRITE 1'b1
`endif
`ifndef RF_NOP
`define RF_NOP 1'b0
`endif

module rf_writeback #(
  parameter int unsigned LEN   = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_rdy_in,
  input  logic           i_alu_valid,
  input  logic [4:0]     i_alu_rd,
  input  logic [LEN-1:0] i_alu_data,
  output logic           o_alu_ready,
  input  logic           i_mem_valid,
  input  logic [4:0]     i_mem_rd,
  input  logic [LEN-1:0] i_mem_data,
  output logic           o_mem_ready,
  input  logic           i_issue_valid,
  input  logic [4:0]     i_issue_rd,
  input  logic [4:0]     i_rs1,
  input  logic [4:0]     i_rs2,
  output logic           o_rs1_busy,
  output logic           o_rs2_busy,
  output logic           o_rf_signal,
  output logic [4:0]     o_rf_rd,
  output logic [LEN-1:0] o_rf_data
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  // Source index 0 is the ALU, index 1 is the load/store unit.
  logic [1:0]     w_in_valid;
  logic [4:0]     w_in_rd     [2];
  logic [LEN-1:0] w_in_data   [2];
  logic [1:0]     w_ready;
  logic [1:0]     w_push;
  logic [1:0]     w_nonempty;
  logic [1:0]     w_grant;
  logic [4:0]     w_head_rd   [2];
  logic [LEN-1:0] w_head_data [2];
  logic [4:0]     w_sel_rd;
  logic [LEN-1:0] w_sel_data;
  logic [31:0]    w_busy_nxt;

  logic           r_last_mem;
  logic           r_rf_signal;
  logic [4:0]     r_rf_rd;
  logic [LEN-1:0] r_rf_data;
  logic [31:0]    r_busy;

  assign w_in_valid   = {i_mem_valid, i_alu_valid};
  assign w_in_rd[0]   = i_alu_rd;
  assign w_in_rd[1]   = i_mem_rd;
  assign w_in_data[0] = i_alu_data;
  assign w_in_data[1] = i_mem_data;

  for (genvar s = 0; s < 2; s++) begin : g_fifo
    logic [4:0]      r_rd   [DEPTH];
    logic [LEN-1:0]  r_data [DEPTH];
    logic [PtrW-1:0] r_wptr;
    logic [PtrW-1:0] r_rptr;
    logic [CntW-1:0] r_count;

    // Ready looks only at the current count, so a full FIFO refuses even if it pops.
    assign w_nonempty[s]  = (r_count != '0);
    assign w_ready[s]     = i_rdy_in && (r_count < CntW'(DEPTH));
    assign w_push[s]      = w_in_valid[s] && w_ready[s];
    assign w_head_rd[s]   = r_rd[r_rptr];
    assign w_head_data[s] = r_data[r_rptr];

    // Circular buffer; the pop is the arbiter grant, frozen with the global enable
    always_ff @(posedge i_clk) begin
      if (!i_rst) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else if (i_rdy_in) begin
        if (w_push[s]) begin
          r_rd[r_wptr]   <= w_in_rd[s];
          r_data[r_wptr] <= w_in_data[s];
          r_wptr         <= (r_wptr == PtrW'(DEPTH - 1)) ? '0 : r_wptr + PtrW'(1);
        end
        if (w_grant[s]) begin
          r_rptr <= (r_rptr == PtrW'(DEPTH - 1)) ? '0 : r_rptr + PtrW'(1);
        end
        r_count <= r_count + CntW'(w_push[s]) - CntW'(w_grant[s]);
      end
    end
  end

  assign o_alu_ready = w_ready[0];
  assign o_mem_ready = w_ready[1];

  // Round-robin: with both heads present, favour the source not granted last
  always_comb begin
    w_grant = 2'b00;
    unique case (w_nonempty)
      2'b01:   w_grant = 2'b01;
      2'b10:   w_grant = 2'b10;
      2'b11:   w_grant = r_last_mem ? 2'b01 : 2'b10;
      default: w_grant = 2'b00;
    endcase
  end

  assign w_sel_rd   = w_grant[1] ? w_head_rd[1]   : w_head_rd[0];
  assign w_sel_data = w_grant[1] ? w_head_data[1] : w_head_data[0];

  // Registered write port; an x0 head is consumed as a grant but never written
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_last_mem  <= 1'b0;
      r_rf_signal <= `RF_NOP;
      r_rf_rd     <= '0;
      r_rf_data   <= '0;
    end else if (i_rdy_in) begin
      r_rf_signal <= `RF_NOP;
      if (w_grant != 2'b00) begin
        r_last_mem <= w_grant[1];
        if (w_sel_rd != 5'd0) begin
          r_rf_signal <= `RF_WRITE;
          r_rf_rd     <= w_sel_rd;
          r_rf_data   <= w_sel_data;
        end
      end
    end
  end

  // Scoreboard next state: commit clears first, then issue sets, so set wins
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_rf_signal == `RF_WRITE) begin
      w_busy_nxt[r_rf_rd] = 1'b0;
    end
    if (i_issue_valid) begin
      w_busy_nxt[i_issue_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Scoreboard register, cleared on the same edge the register file commits
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_busy <= '0;
    end else if (i_rdy_in) begin
      r_busy <= w_busy_nxt;
    end
  end

  assign o_rs1_busy  = (i_rs1 != 5'd0) && r_busy[i_rs1];
  assign o_rs2_busy  = (i_rs2 != 5'd0) && r_busy[i_rs2];
  assign o_rf_signal = r_rf_signal;
  assign o_rf_rd     = r_rf_rd;
  assign o_rf_data   = r_rf_data;

endmodule

// File: tb/tb_rf_writeback.sv
// Self-checking bench for rf_writeback: directed vector table, a hand-written
// backpressure sequence, then random traffic against a queue-based model.

`ifndef RF_WRITE
`define RF_WRITE 1'b1
`endif
`ifndef RF_NOP
`define RF_NOP 1'b0
`endif

module tb_rf_writeback;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst, rdy;
  logic        av, mv, iv;
  logic [4:0]  ard, mrd, ird, rs1, rs2;
  logic [31:0] adat, mdat;
  logic        ar, mr, b1, b2, sig;
  logic [4:0]  rd;
  logic [31:0] data;

  int n_checks;
  int n_fail;

  rf_writeback #(
    .LEN   (32),
    .DEPTH (DEPTH)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_rdy_in      (rdy),
    .i_alu_valid   (av),
    .i_alu_rd      (ard),
    .i_alu_data    (adat),
    .o_alu_ready   (ar),
    .i_mem_valid   (mv),
    .i_mem_rd      (mrd),
    .i_mem_data    (mdat),
    .o_mem_ready   (mr),
    .i_issue_valid (iv),
    .i_issue_rd    (ird),
    .i_rs1         (rs1),
    .i_rs2         (rs2),
    .o_rs1_busy    (b1),
    .o_rs2_busy    (b2),
    .o_rf_signal   (sig),
    .o_rf_rd       (rd),
    .o_rf_data     (data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        m_qa[$];
  ent_t        m_qm[$];
  logic        m_last_mem;
  logic [31:0] m_busy;
  logic        m_sig;
  logic [4:0]  m_rd;
  logic [31:0] m_data;

  function automatic void model_reset();
    m_qa.delete();
    m_qm.delete();
    m_last_mem = 1'b0;
    m_busy     = '0;
    m_sig      = 1'b0;
    m_rd       = '0;
    m_data     = '0;
  endfunction

  // One clock edge, evaluated with the inputs currently applied.
  function automatic void model_step();
    ent_t e;
    int   g;
    logic acc_a, acc_m;
    if (!rst) begin
      model_reset();
      return;
    end
    if (!rdy) return;
    acc_a = av && (m_qa.size() < DEPTH);
    acc_m = mv && (m_qm.size() < DEPTH);
    g = -1;
    if (m_qa.size() > 0 && m_qm.size() > 0) g = m_last_mem ? 0 : 1;
    else if (m_qa.size() > 0) g = 0;
    else if (m_qm.size() > 0) g = 1;
    if (m_sig) m_busy[m_rd] = 1'b0;
    if (iv && ird != 0) m_busy[ird] = 1'b1;
    m_sig = 1'b0;
    if (g >= 0) begin
      if (g == 0) e = m_qa.pop_front();
      else e = m_qm.pop_front();
      m_last_mem = (g == 1);
      if (e.rd != 0) begin
        m_sig  = 1'b1;
        m_rd   = e.rd;
        m_data = e.data;
      end
    end
    if (acc_a) m_qa.push_back({ard, adat});
    if (acc_m) m_qm.push_back({mrd, mdat});
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_idle();
    rst = 1'b1; rdy = 1'b1;
    av = 1'b0; ard = '0; adat = '0;
    mv = 1'b0; mrd = '0; mdat = '0;
    iv = 1'b0; ird = '0; rs1 = '0; rs2 = '0;
  endtask

  typedef struct {
    logic        chk;
    logic        rst, rdy;
    logic        av;  logic [4:0] ard; logic [31:0] adat;
    logic        mv;  logic [4:0] mrd; logic [31:0] mdat;
    logic        iv;  logic [4:0] ird;
    logic [4:0]  rs1, rs2;
    logic        e_ar, e_mr, e_b1, e_b2, e_sig;
    logic [4:0]  e_rd;
    logic [31:0] e_dat;
  } vec_t;

  vec_t vecs[$];

  // Row = inputs held for one cycle plus the outputs expected within that cycle.
  function automatic vec_t mk(
    input logic c, input logic r, input logic y,
    input logic a, input logic [4:0] a_rd, input logic [31:0] a_d,
    input logic m, input logic [4:0] m_rd_i, input logic [31:0] m_d,
    input logic i, input logic [4:0] i_rd, input logic [4:0] s1, input logic [4:0] s2,
    input logic x_ar, input logic x_mr, input logic x_b1, input logic x_b2,
    input logic x_sig, input logic [4:0] x_rd, input logic [31:0] x_d);
    vec_t v;
    v.chk = c; v.rst = r; v.rdy = y;
    v.av = a; v.ard = a_rd; v.adat = a_d;
    v.mv = m; v.mrd = m_rd_i; v.mdat = m_d;
    v.iv = i; v.ird = i_rd; v.rs1 = s1; v.rs2 = s2;
    v.e_ar = x_ar; v.e_mr = x_mr; v.e_b1 = x_b1; v.e_b2 = x_b2;
    v.e_sig = x_sig; v.e_rd = x_rd; v.e_dat = x_d;
    return v;
  endfunction

  logic [36:0] got[$];
  logic [36:0] bp_exp [4];
  logic        a3_pending;
  logic        acc;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_reset();
    set_idle();
    rst = 1'b0;

    // reset held two cycles with a pending ALU result, then released
    vecs.push_back(mk(0, 0,1, 1,3,32'hAAAA, 0,0,0, 0,0, 3,3, 0,0,0,0, 0,0,0));
    vecs.push_back(mk(1, 0,1, 1,3,32'hAAAA, 0,0,0, 0,0, 3,3, 1,1,0,0, 0,0,0));
    vecs.push_back(mk(1, 1,1, 0,0,0,        0,0,0, 0,0, 3,0, 1,1,0,0, 0,0,0));
    vecs.push_back(mk(1, 1,1, 0,0,0,        0,0,0, 0,0, 3,0, 1,1,0,0, 0,0,0));
    // single ALU write: issue 5, result accepted three edges later
    vecs.push_back(mk(1, 1,1, 0,0,0,            0,0,0, 1,5, 5,0, 1,1,0,0, 0,0,0));
    vecs.push_back(mk(1, 1,1, 0,0,0,            0,0,0, 0,0, 5,0, 1,1,1,0, 0,0,0));
    vecs.push_back(mk(1, 1,1, 0,0,0,            0,0,0, 0,0, 5,0, 1,1,1,0, 0,0,0));
    vecs.push_back(mk(1, 1,1, 1,5,32'hDEADBEEF, 0,0,0, 0,0, 5,0, 1,1,1,0, 0,0,0));
    vecs.push_back(mk(1, 1,1, 0,0,0,            0,0,0, 0,0, 5,5, 1,1,1,1, 0,0,0));
    vecs.push_back(mk(1, 1,1, 0,0,0, 0,0,0, 0,0, 5,5, 1,1,1,1, 1,5,32'hDEADBEEF));
    vecs.push_back(mk(1, 1,1, 0,0,0, 0,0,0, 0,0, 5,5, 1,1,0,0, 0,5,32'hDEADBEEF));
    // contention: alternating grants, full ALU FIFO refuses A3 once
    vecs.push_back(mk(1, 1,1, 1,10,32'hA1, 1,20,32'hB1, 0,0, 0,0, 1,1,0,0, 0,5,32'hDEADBEEF));
    vecs.push_back(mk(1, 1,1, 1,11,32'hA2, 1,21,32'hB2, 0,0, 0,0, 1,1,0,0, 0,5,32'hDEADBEEF));
    vecs.push_back(mk(1, 1,1, 1,12,32'hA3, 0,0,0,       0,0, 0,0, 0,1,0,0, 1,20,32'hB1));
    vecs.push_back(mk(1, 1,1, 1,12,32'hA3, 0,0,0,       0,0, 0,0, 1,1,0,0, 1,10,32'hA1));
    vecs.push_back(mk(1, 1,1, 0,0,0,       0,0,0,       0,0, 0,0, 0,1,0,0, 1,21,32'hB2));
    vecs.push_back(mk(1, 1,1, 0,0,0,       0,0,0,       0,0, 0,0, 1,1,0,0, 1,11,32'hA2));
    vecs.push_back(mk(1, 1,1, 0,0,0,       0,0,0,       0,0, 0,0, 1,1,0,0, 1,12,32'hA3));
    vecs.push_back(mk(1, 1,1, 0,0,0,       0,0,0,       0,0, 0,0, 1,1,0,0, 0,12,32'hA3));
    // x0 result is dropped; the entry behind it commits next cycle
    vecs.push_back(mk(1, 1,1, 1,0,32'h1234,  0,0,0, 1,9, 9,0, 1,1,0,0, 0,12,32'hA3));
    vecs.push_back(mk(1, 1,1, 1,13,32'h5555, 0,0,0, 0,0, 9,0, 1,1,1,0, 0,12,32'hA3));
    vecs.push_back(mk(1, 1,1, 0,0,0,         0,0,0, 0,0, 9,0, 1,1,1,0, 0,12,32'hA3));
    vecs.push_back(mk(1, 1,1, 0,0,0,         0,0,0, 0,0, 9,0, 1,1,1,0, 1,13,32'h5555));
    vecs.push_back(mk(1, 1,1, 0,0,0,         0,0,0, 0,0, 9,0, 1,1,1,0, 0,13,32'h5555));
    // set/clear collision on register 7
    vecs.push_back(mk(1, 1,1, 0,0,0, 1,9,32'h99, 1,7, 7,9, 1,1,0,1, 0,13,32'h5555));
    vecs.push_back(mk(1, 1,1, 0,0,0, 1,7,32'h77, 0,0, 7,9, 1,1,1,1, 0,13,32'h5555));
    vecs.push_back(mk(1, 1,1, 0,0,0, 0,0,0,      0,0, 7,9, 1,1,1,1, 1,9,32'h99));
    vecs.push_back(mk(1, 1,1, 0,0,0, 0,0,0,      1,7, 7,9, 1,1,1,0, 1,7,32'h77));
    vecs.push_back(mk(1, 1,1, 0,0,0, 0,0,0,      0,0, 7,9, 1,1,1,0, 0,7,32'h77));

    foreach (vecs[i]) begin
      rst = vecs[i].rst; rdy = vecs[i].rdy;
      av = vecs[i].av; ard = vecs[i].ard; adat = vecs[i].adat;
      mv = vecs[i].mv; mrd = vecs[i].mrd; mdat = vecs[i].mdat;
      iv = vecs[i].iv; ird = vecs[i].ird; rs1 = vecs[i].rs1; rs2 = vecs[i].rs2;
      @(negedge clk);
      if (vecs[i].chk) begin
        chk($sformatf("vec%0d alu_ready", i), 32'(ar), 32'(vecs[i].e_ar));
        chk($sformatf("vec%0d mem_ready", i), 32'(mr), 32'(vecs[i].e_mr));
        chk($sformatf("vec%0d rs1_busy", i), 32'(b1), 32'(vecs[i].e_b1));
        chk($sformatf("vec%0d rs2_busy", i), 32'(b2), 32'(vecs[i].e_b2));
        chk($sformatf("vec%0d rf_signal", i), 32'(sig), 32'(vecs[i].e_sig));
        chk($sformatf("vec%0d rf_rd", i), 32'(rd), 32'(vecs[i].e_rd));
        chk($sformatf("vec%0d rf_data", i), data, vecs[i].e_dat);
      end
      tick();
    end

    // backpressure: ALU FIFO fills, writer stalls, nothing is lost
    set_idle(); rst = 1'b0;
    @(negedge clk); tick();
    set_idle(); av = 1; ard = 1; adat = 32'h11; mv = 1; mrd = 17; mdat = 32'h71;
    @(negedge clk);
    chk("bp0 alu_ready", 32'(ar), 1);
    chk("bp0 mem_ready", 32'(mr), 1);
    tick();
    set_idle(); av = 1; ard = 2; adat = 32'h22; mv = 1; mrd = 18; mdat = 32'h72;
    @(negedge clk);
    chk("bp1 alu_ready", 32'(ar), 1);
    tick();
    for (int k = 0; k < 2; k++) begin
      set_idle(); rdy = 0; av = 1; ard = 3; adat = 32'h33; iv = 1; ird = 25;
      @(negedge clk);
      chk($sformatf("bp stall%0d alu_ready", k), 32'(ar), 0);
      chk($sformatf("bp stall%0d mem_ready", k), 32'(mr), 0);
      chk($sformatf("bp stall%0d rf_signal", k), 32'(sig), 1);
      chk($sformatf("bp stall%0d rf_rd", k), 32'(rd), 17);
      chk($sformatf("bp stall%0d rf_data", k), data, 32'h71);
      tick();
    end
    set_idle(); av = 1; ard = 3; adat = 32'h33; rs1 = 25;
    @(negedge clk);
    chk("bp full alu_ready", 32'(ar), 0);
    chk("bp frozen issue busy", 32'(b1), 0);
    tick();
    a3_pending = 1'b1;
    for (int k = 0; k < 12 && got.size() < 4; k++) begin
      set_idle();
      if (a3_pending) begin
        av = 1; ard = 3; adat = 32'h33;
      end
      @(negedge clk);
      if (sig == `RF_WRITE) got.push_back({rd, data});
      acc = ar && av;
      tick();
      if (acc) a3_pending = 1'b0;
    end
    chk("bp a3 accepted", 32'(a3_pending), 0);
    chk("bp commit count", 32'(got.size()), 4);
    bp_exp[0] = {5'd1, 32'h11};
    bp_exp[1] = {5'd18, 32'h72};
    bp_exp[2] = {5'd2, 32'h22};
    bp_exp[3] = {5'd3, 32'h33};
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      chk($sformatf("bp commit%0d rd", i), 32'(got[i][36:32]), 32'(bp_exp[i][36:32]));
      chk($sformatf("bp commit%0d data", i), got[i][31:0], bp_exp[i][31:0]);
    end

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst  = ($urandom_range(0, 99) != 0);
      rdy  = ($urandom_range(0, 4) != 0);
      av   = 1'($urandom_range(0, 1));
      ard  = 5'($urandom_range(0, 31));
      adat = $urandom;
      mv   = 1'($urandom_range(0, 1));
      mrd  = 5'($urandom_range(0, 31));
      mdat = $urandom;
      iv   = 1'($urandom_range(0, 1));
      ird  = 5'($urandom_range(0, 31));
      rs1  = 5'($urandom_range(0, 31));
      rs2  = 5'($urandom_range(0, 31));
      @(negedge clk);
      chk("rnd alu_ready", 32'(ar), 32'(rdy && (m_qa.size() < DEPTH)));
      chk("rnd mem_ready", 32'(mr), 32'(rdy && (m_qm.size() < DEPTH)));
      chk("rnd rs1_busy", 32'(b1), 32'((rs1 != 0) && m_busy[rs1]));
      chk("rnd rs2_busy", 32'(b2), 32'((rs2 != 0) && m_busy[rs2]));
      chk("rnd rf_signal", 32'(sig), 32'(m_sig));
      chk("rnd rf_rd", 32'(rd), 32'(m_rd));
      chk("rnd rf_data", data, m_data);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_writeback.md
# rf_writeback

Write-back stage and register scoreboard driving the write port of the 32×32 register file. It accepts completed results from the ALU and the load/store unit through valid/ready channels and buffers each in a 2-entry FIFO. Each cycle it arbitrates round-robin between the two sources and issues at most one registered write to the register file. It also keeps a per-register busy vector that decode sets on issue and write-back clears on commit; decode reads that vector for RAW stalls.

## Interface
- LEN, 32, data width
- DEPTH, 2, entries per source FIFO (power of two)
- clk  in  1  clock, all state on posedge
- rst  in  1  synchronous reset, active-low
- rdy_in  in  1  global enable; low freezes all state
- alu_valid  in  1  ALU result available
- alu_rd  in  5  ALU destination index
- alu_data  in  LEN  ALU result
- alu_ready  out  1  ALU FIFO can accept
- mem_valid  in  1  load result available
- mem_rd  in  5  load destination index
- mem_data  in  LEN  load result
- mem_ready  out  1  mem FIFO can accept
- issue_valid  in  1  decode issued an instruction that writes rd
- issue_rd  in  5  its destination index
- rs1, rs2  in  5 each  decode source indices
- rs1_busy, rs2_busy  out  1 each  combinational busy[rs1], busy[rs2]; always 0 for index 0
- rf_signal  out  1  `RF_WRITE` or `RF_NOP` (shared defines), registered
- rf_rd  out  5  write index, registered
- rf_data  out  LEN  write data, registered

## Operation
- Reset (rst==0 at posedge): both FIFOs empty, round-robin pointer = ALU, busy vector = 0, rf_signal=`RF_NOP`, rf_rd=0, rf_data=0. Reset overrides rdy_in and discards in-flight entries.
- rdy_in==0: no push, no pop, no busy update, outputs hold; alu_ready and mem_ready are 0.
- Push: on posedge, when rdy_in and X_valid and X_ready, append {X_rd, X_data}. X_ready = rdy_in && count_X < DEPTH. Push and pop on the same FIFO in the same cycle are allowed when it is not full.
- Arbitration (combinational on FIFO heads):
  - Exactly one FIFO non-empty: grant it.
  - Both non-empty: grant the source that was not granted last.
  - Neither: grant none.
  - After a grant, the pointer records the granted source.
- Pop: the granted head is popped at posedge.
  - Head rd != 0: rf_signal<=`RF_WRITE`, rf_rd<=rd, rf_data<=data.
  - Head rd == 0: popped, rf_signal<=`RF_NOP`, and it still counts as the grant.
  - No grant: rf_signal<=`RF_NOP`; rf_rd and rf_data hold.
- Busy vector:
  - Set busy[issue_rd] on posedge when rdy_in, issue_valid and issue_rd != 0.
  - Clear busy[rf_rd] on posedge when rdy_in and the registered rf_signal==`RF_WRITE`. This is the same edge the register file commits.
  - Set and clear of the same index on one edge: set wins.
  - busy[0] is never set.
- Protocol rules (decode enforces; not checked here):
  - Decode never issues to an rd that is already busy.
  - Each issued rd returns exactly one result.

## Timing
- Result accepted at edge N → rf_signal=`RF_WRITE` in the cycle after edge N+1 when uncontested → register file writes at edge N+2 → busy clears at edge N+2.
- Contended: each source waits at most one extra cycle per competing head.
- Throughput: one commit per cycle total, sustained.
- FIFO full: X_ready=0 in the same cycle, combinational from count; no entry is dropped.
- rdy_in low for k cycles stretches every latency by exactly k.

## Test plan
- Reset: hold rst=0 for 2 cycles with alu_valid=1 → after release rf_signal=`RF_NOP`, busy all 0, both readys 1, no write from the pre-reset valid.
- Single ALU write: issue_rd=5 at edge 0; alu rd=5, data=0xDEADBEEF accepted at edge 3 → rf_signal=`RF_WRITE`, rf_rd=5, rf_data=0xDEADBEEF after edge 4. rs1=5 gives rs1_busy=1 until edge 5, then 0.
- Contention: both FIFOs hold 2 entries (ALU A1,A2 / mem M1,M2), pointer=ALU → commit order M1, A1, M2, A2 on 4 consecutive cycles.
- Full/backpressure: 3 ALU results offered back-to-back while mem is busy and the writer is stalled by rdy_in=0 → alu_ready=0 on the third; after rdy_in=1 all 3 commit in order, none lost.
- x0 discard: alu rd=0, data=0x1234 → popped, rf_signal stays `RF_NOP`, busy unchanged, next queued entry commits the following cycle.
- Set/clear collision: rf_signal=`RF_WRITE` with rf_rd=7 on the same edge as issue_valid with issue_rd=7 → busy[7]=1 afterwards.
